// File: rtl/raw8_bayer_mosaic_if.sv
// Video port bundle for the RGB888-to-RAW8 mosaic stage: upstream RGB side and downstream RAW side.
interface raw8_bayer_mosaic_if;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [23:0] per_img_rgb888;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [7:0]  post_img_RAW;
    logic        line_len_err;
    logic        frame_len_err;
    logic        frame_done;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_rgb888,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_RAW,
        input  line_len_err, frame_len_err, frame_done
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_rgb888,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_RAW,
        output line_len_err, frame_len_err, frame_done
    );
endinterface

// File: rtl/raw8_bayer_mosaic.sv
// RGB888 to Bayer RAW8 re-mosaic: keeps one channel per pixel following a 2x2 CFA phase,
// delays sync by one clock and checks frame geometry.
module raw8_bayer_mosaic #(
    parameter int unsigned IMG_HDISP     = 640,
    parameter int unsigned IMG_VDISP     = 480,
    parameter int unsigned BAYER_PATTERN = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    raw8_bayer_mosaic_if.slave   vp
);
    localparam int unsigned     CNT_W   = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] HDISP_C = CNT_W'(IMG_HDISP);
    localparam logic [CNT_W-1:0] VDISP_C = CNT_W'(IMG_VDISP);
    localparam logic [1:0]       PHASE0  = 2'(BAYER_PATTERN);

    typedef enum logic [1:0] {WAIT_SYNC, IDLE, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic             vsync_d, href_d;
    logic [CNT_W-1:0] point_cnt, line_cnt;

    logic             vs_rise_c, vs_fall_c, href_fall_c, enter_active_c;
    logic [1:0]       phase_c;
    logic [7:0]       chan_c;
    logic [CNT_W-1:0] line_cnt_upd_c, line_cnt_nxt_c;
    logic [7:0]       raw_nxt_c;
    logic             frame_done_nxt_c, frame_len_err_nxt_c, line_len_err_nxt_c;

    assign vs_rise_c      = vp.per_frame_vsync & ~vsync_d;
    assign vs_fall_c      = ~vp.per_frame_vsync & vsync_d;
    assign href_fall_c    = ~vp.per_frame_href & href_d;
    assign enter_active_c = (state == IDLE) && vs_rise_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= WAIT_SYNC;
        else        state <= state_nxt;
    end

    // Next-state logic; WAIT_SYNC swallows any frame already in progress at reset
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SYNC: if (!vp.per_frame_vsync) state_nxt = IDLE;
            IDLE:      if (vs_rise_c)           state_nxt = ACTIVE;
            ACTIVE:    if (vs_fall_c)           state_nxt = IDLE;
            default:                            state_nxt = WAIT_SYNC;
        endcase
    end

    // Output logic; the line count is bumped before the frame check so a line ending with vsync counts
    always_comb begin
        phase_c             = {line_cnt[0], point_cnt[0]} ^ PHASE0;
        chan_c              = vp.per_img_rgb888[15:8];
        line_cnt_upd_c      = line_cnt;
        line_cnt_nxt_c      = line_cnt;
        raw_nxt_c           = 8'h00;
        frame_done_nxt_c    = 1'b0;
        frame_len_err_nxt_c = 1'b0;
        line_len_err_nxt_c  = vp.line_len_err;

        case (phase_c)
            2'b00:   chan_c = vp.per_img_rgb888[23:16];
            2'b11:   chan_c = vp.per_img_rgb888[7:0];
            default: chan_c = vp.per_img_rgb888[15:8];
        endcase

        if ((state == ACTIVE) && href_fall_c && (line_cnt != CNT_MAX))
            line_cnt_upd_c = line_cnt + CNT_W'(1);
        line_cnt_nxt_c = enter_active_c ? '0 : line_cnt_upd_c;

        if ((state == ACTIVE) && vp.per_frame_href)
            raw_nxt_c = chan_c;

        frame_done_nxt_c    = (state == ACTIVE) && vs_fall_c;
        frame_len_err_nxt_c = frame_done_nxt_c && (line_cnt_upd_c != VDISP_C);

        if (enter_active_c)
            line_len_err_nxt_c = 1'b0;
        else if ((state == ACTIVE) && href_fall_c && (point_cnt != HDISP_C))
            line_len_err_nxt_c = 1'b1;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d             <= 1'b0;
            href_d              <= 1'b0;
            point_cnt           <= '0;
            line_cnt            <= '0;
            vp.post_frame_vsync <= 1'b0;
            vp.post_frame_href  <= 1'b0;
            vp.post_frame_clken <= 1'b0;
            vp.post_img_RAW     <= 8'h00;
            vp.line_len_err     <= 1'b0;
            vp.frame_len_err    <= 1'b0;
            vp.frame_done       <= 1'b0;
        end else begin
            vsync_d             <= vp.per_frame_vsync;
            href_d              <= vp.per_frame_href;
            line_cnt            <= line_cnt_nxt_c;
            vp.post_frame_vsync <= vp.per_frame_vsync;
            vp.post_frame_href  <= vp.per_frame_href;
            vp.post_frame_clken <= vp.per_frame_clken;
            vp.post_img_RAW     <= raw_nxt_c;
            vp.line_len_err     <= line_len_err_nxt_c;
            vp.frame_len_err    <= frame_len_err_nxt_c;
            vp.frame_done       <= frame_done_nxt_c;
            if (!vp.per_frame_href)
                point_cnt <= '0;
            else if (vp.per_frame_clken && (point_cnt != CNT_MAX))
                point_cnt <= point_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_raw8_bayer_mosaic.sv
// Directed bench for raw8_bayer_mosaic: RGGB and BGGR instances on a 4x2 geometry.
module tb_raw8_bayer_mosaic;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    raw8_bayer_mosaic_if vif_a ();
    raw8_bayer_mosaic_if vif_b ();

    raw8_bayer_mosaic #(.IMG_HDISP(4), .IMG_VDISP(2), .BAYER_PATTERN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .vp(vif_a.slave));
    raw8_bayer_mosaic #(.IMG_HDISP(4), .IMG_VDISP(2), .BAYER_PATTERN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .vp(vif_b.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] a0 [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    logic [7:0] a1 [4] = '{8'h22, 8'h33, 8'h22, 8'h33};
    logic [7:0] b0 [4] = '{8'h33, 8'h22, 8'h33, 8'h22};
    logic [7:0] b1 [4] = '{8'h22, 8'h11, 8'h22, 8'h11};
    logic [7:0] zz [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

    localparam logic [23:0] PIX = 24'h112233;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One input cycle: drive on the falling edge, return #1 after the capturing rising edge
    task automatic drive(input logic vs, input logic hr, input logic ce, input logic [23:0] rgb);
        @(negedge clk);
        vif_a.per_frame_vsync = vs; vif_a.per_frame_href = hr;
        vif_a.per_frame_clken = ce; vif_a.per_img_rgb888 = rgb;
        vif_b.per_frame_vsync = vs; vif_b.per_frame_href = hr;
        vif_b.per_frame_clken = ce; vif_b.per_img_rgb888 = rgb;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input string tag, input int npix, input int ngap,
                        input logic [7:0] ea [4], input logic [7:0] eb [4]);
        for (int i = 0; i < npix; i++) begin
            drive(1'b1, 1'b1, 1'b1, PIX);
            chk($sformatf("%s_a_p%0d", tag, i), vif_a.post_img_RAW, ea[i]);
            chk($sformatf("%s_b_p%0d", tag, i), vif_b.post_img_RAW, eb[i]);
        end
        for (int g = 0; g < ngap; g++) drive(1'b1, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("rst_raw",   vif_a.post_img_RAW,     0);
        chk("rst_done",  vif_a.frame_done,       0);
        chk("rst_lerr",  vif_a.line_len_err,     0);
        chk("rst_ferr",  vif_a.frame_len_err,    0);
        chk("rst_vs",    vif_a.post_frame_vsync, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);

        // Frame 1: nominal 4x2
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        chk("f1_vs_dly", vif_a.post_frame_vsync, 1);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f1_l0", 4, 2, a0, b0);
        chk("f1_done_mid", vif_a.frame_done, 0);
        line("f1_l1", 4, 2, a1, b1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f1_done",  vif_a.frame_done,    1);
        chk("f1_ferr",  vif_a.frame_len_err, 0);
        chk("f1_lerr",  vif_a.line_len_err,  0);
        chk("f1_done_b", vif_b.frame_done,   1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f1_done_pulse", vif_a.frame_done, 0);

        // Frame 2: clken gap holds the phase; bit-exact bytes
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b1, 1'b1, 24'hAABBCC);
        chk("f2_a_p0", vif_a.post_img_RAW, 8'hAA);
        chk("f2_b_p0", vif_b.post_img_RAW, 8'hCC);
        drive(1'b1, 1'b1, 1'b0, 24'hAABBCC);
        chk("f2_a_gap", vif_a.post_img_RAW, 8'hBB);
        chk("f2_b_gap", vif_b.post_img_RAW, 8'hBB);
        chk("f2_ce_dly", vif_a.post_frame_clken, 0);
        drive(1'b1, 1'b1, 1'b1, 24'hAABBCC);
        chk("f2_a_p1", vif_a.post_img_RAW, 8'hBB);
        drive(1'b1, 1'b1, 1'b1, 24'hAABBCC);
        chk("f2_a_p2", vif_a.post_img_RAW, 8'hAA);
        chk("f2_b_p2", vif_b.post_img_RAW, 8'hCC);
        drive(1'b1, 1'b1, 1'b1, 24'hAABBCC);
        chk("f2_a_p3", vif_a.post_img_RAW, 8'hBB);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        chk("f2_href_off_raw", vif_a.post_img_RAW, 0);
        chk("f2_lerr", vif_a.line_len_err, 0);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f2_l1", 4, 2, a1, b1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f2_ferr", vif_a.frame_len_err, 0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);

        // Frame 3: short first line sets the sticky error
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f3_l0", 3, 1, a0, b0);
        chk("f3_lerr_set", vif_a.line_len_err, 1);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f3_l1", 4, 2, a1, b1);
        chk("f3_lerr_sticky", vif_a.line_len_err, 1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f3_done", vif_a.frame_done,    1);
        chk("f3_ferr", vif_a.frame_len_err, 0);
        chk("f3_lerr_end", vif_a.line_len_err, 1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        chk("f4_lerr_clr", vif_a.line_len_err, 0);

        // Frame 4: three lines against a two-line geometry
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f4_l0", 4, 2, a0, b0);
        line("f4_l1", 4, 2, a1, b1);
        line("f4_l2", 4, 2, a0, b0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f4_done", vif_a.frame_done,    1);
        chk("f4_ferr", vif_a.frame_len_err, 1);
        chk("f4_lerr", vif_a.line_len_err,  0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f4_ferr_pulse", vif_a.frame_len_err, 0);

        // Frame 5: last (short) line ends together with vsync
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f5_l0", 4, 2, a0, b0);
        line("f5_l1", 3, 0, a1, b1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f5_done", vif_a.frame_done,    1);
        chk("f5_ferr", vif_a.frame_len_err, 0);
        chk("f5_lerr", vif_a.line_len_err,  1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);

        // Frame 6: reset in the middle of a line
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f6_l0", 2, 0, a0, b0);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, PIX);
        drive(1'b1, 1'b1, 1'b1, PIX);
        chk("f6_rst_href", vif_a.post_frame_href, 0);
        chk("f6_rst_raw",  vif_a.post_img_RAW,    0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, PIX);
        chk("f6_raw_blank", vif_a.post_img_RAW,    0);
        chk("f6_href_dly",  vif_a.post_frame_href, 1);
        chk("f6_vs_dly",    vif_a.post_frame_vsync, 1);
        drive(1'b1, 1'b1, 1'b1, PIX);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f6_l1", 4, 2, zz, zz);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f6_no_done", vif_a.frame_done,    0);
        chk("f6_no_ferr", vif_a.frame_len_err, 0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);

        // Frame 7: clean recovery after reset
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        line("f7_l0", 4, 2, a0, b0);
        line("f7_l1", 4, 2, a1, b1);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        chk("f7_done", vif_a.frame_done,    1);
        chk("f7_ferr", vif_a.frame_len_err, 0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/raw8_bayer_mosaic.md
# raw8_bayer_mosaic

Converts an RGB888 pixel stream back into an 8-bit Bayer RAW stream by keeping one colour channel per pixel position. The channel follows a configurable 2x2 CFA phase. The block is the inverse of the team's RAW8-to-RGB888 demosaic stage. It feeds that stage with synthetic RAW frames built from RGB test images, and it also serves as a RAW re-encoder ahead of storage. It uses the same vsync/href/clken video-port convention as the rest of the VIP pipeline, and it adds frame-geometry checking.

## Interface
Parameters:
- IMG_HDISP, 640, active pixels per line
- IMG_VDISP, 480, active lines per frame
- BAYER_PATTERN, 0, CFA phase of line 0 / pixel 0: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR. Default RGGB matches the demosaic stage: even line R G R G, odd line G B G B.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset. One clock domain; reset is synchronous and active-low.
- per_frame_vsync  in  1  frame valid, active high
- per_frame_href  in  1  line valid, active high
- per_frame_clken  in  1  pixel qualifier
- per_img_rgb888  in  24  {R[23:16], G[15:8], B[7:0]}
- post_frame_vsync  out  1  per_frame_vsync delayed 1 clk
- post_frame_href  out  1  per_frame_href delayed 1 clk
- post_frame_clken  out  1  per_frame_clken delayed 1 clk
- post_img_RAW  out  8  mosaicked pixel; 0 when post_frame_href=0 or the FSM is not in ACTIVE
- line_len_err  out  1  sticky: a line in the current frame had a pixel count other than IMG_HDISP
- frame_len_err  out  1  single-cycle pulse at frame end if the line count is not IMG_VDISP
- frame_done  out  1  single-cycle pulse at the falling edge of every ACTIVE frame

## Operation
- FSM states: WAIT_SYNC, IDLE, ACTIVE.
  - Reset state is WAIT_SYNC.
  - WAIT_SYNC goes to IDLE when per_frame_vsync=0. This discards a partial frame after reset.
  - IDLE goes to ACTIVE on the vsync rising edge.
  - ACTIVE goes to IDLE on the vsync falling edge. frame_done pulses on this transition.
- Edge detection uses a registered copy of vsync/href. An edge is defined as current input vs previous cycle.
- point_cnt (11 bit):
  - Increments on cycles with href=1 and clken=1.
  - Clears when href=0.
  - Saturates at 2047.
- line_cnt (11 bit):
  - Increments on the href falling edge while in ACTIVE.
  - Clears on entry to ACTIVE.
  - Saturates at 2047.
- Phase select: p = {line_cnt[0], point_cnt[0]} XOR {BAYER_PATTERN[1], BAYER_PATTERN[0]}.
  - p=00 selects R.
  - p=01 and p=10 select G.
  - p=11 selects B.
  - The pixel counter value used is the one before the current pixel's increment.
- No arithmetic is performed on pixel data; the selected byte is passed bit-exact.
- Pixels where clken=0 but href=1 still output the channel for the current, un-advanced phase.
- line_len_err:
  - Set on an href falling edge in ACTIVE when point_cnt does not equal IMG_HDISP.
  - Cleared on entry to ACTIVE.
- frame_len_err: evaluated on ACTIVE-to-IDLE; pulses if line_cnt does not equal IMG_VDISP.
- Reset mid-frame:
  - All registers clear.
  - Outputs are forced to 0 until the next complete frame is seen through WAIT_SYNC and IDLE.
  - Sync outputs resume their 1-clk delay immediately after reset.

## Timing
- Latency is 1 clk from input to all post_* outputs. post_img_RAW stays aligned with post_frame_href and post_frame_clken.
- Reset values: all outputs 0, FSM in WAIT_SYNC, both counters 0.
- frame_done and frame_len_err assert in the cycle after the vsync falling edge, for exactly 1 clk.
- line_len_err is visible in the cycle after the offending href falling edge.
- If vsync falls in the same cycle as href:
  - The line check happens first: line_len_err updates.
  - The line count increments before the frame check, so frame_len_err uses the updated count.
- Input is assumed gap-free in clken. Any clken pattern is tolerated, but the phase advances only on clken.

## Test plan
- Reset, then vsync low, then a 4x2 frame (IMG_HDISP=4, IMG_VDISP=2, RGGB). Every pixel is {R=0x11, G=0x22, B=0x33}.
  - Required post_img_RAW, line 0: 11 22 11 22.
  - Required post_img_RAW, line 1: 22 33 22 33.
  - frame_done pulses once; no errors.
- BAYER_PATTERN=3 (BGGR), same stimulus.
  - Line 0: 33 22 33 22.
  - Line 1: 22 11 22 11.
- Round trip: 640x480 RGB gradient, then this block, then the demosaic stage.
  - At every pixel, the demosaic's centre channel equals the original channel byte.
  - Output sync signals are aligned with no dropped lines.
- One line 3 pixels long in a 4-wide frame.
  - line_len_err rises after that line and stays high to frame end.
  - It clears on the next vsync rise.
  - frame_len_err=0.
- Frame with 3 lines when IMG_VDISP=2: frame_len_err and frame_done both pulse 1 clk after the vsync fall.
- Assert rst_n=0 for 2 clk mid-frame, then release while vsync=1.
  - post_img_RAW stays 0 for the rest of that frame.
  - The next frame is mosaicked correctly starting with R at pixel 0.
